// File: rtl/fm_voice_engine.sv
`default_nettype none
// ============================================================================
// Module      : fm_voice_engine
// Description : Time-multiplexed FM synthesis engine. NUM_VOICES x
//               NUM_OPERATORS operator slots share one phase / sine /
//               envelope pipeline. Features per-slot config fetch,
//               inter-operator phase modulation, saturating carrier mix and
//               per-voice note-on phase reset.
// Ports       : i_Clock, i_Reset        clock, synchronous active-high reset
//               o_CfgVoice/o_CfgOperator slot being issued (config address)
//               i_Cfg*                   config for the issued slot
//               i_NoteOn/i_NoteOnVoice   note-on strobe and voice
//               o_OpResult/o_OpValid     per-slot operator output
//               o_Sample/o_SampleValid   saturated frame mix, 1 pulse/frame
// Revision    : 1.0 - initial release
// ============================================================================
module fm_voice_engine #(
    parameter int NUM_VOICES    = 16,
    parameter int NUM_OPERATORS = 6,
    parameter int PHASE_WIDTH   = 16,
    parameter int ENV_WIDTH     = 16,
    parameter int SAMPLE_WIDTH  = 16,
    localparam int c_VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    localparam int c_OW = (NUM_OPERATORS > 1) ? $clog2(NUM_OPERATORS) : 1
) (
    input  logic                           i_Clock,
    input  logic                           i_Reset,
    output logic [c_VW-1:0]                o_CfgVoice,
    output logic [c_OW-1:0]                o_CfgOperator,
    input  logic [PHASE_WIDTH-1:0]         i_CfgPhaseStep,
    input  logic [ENV_WIDTH-1:0]           i_CfgEnvelope,
    input  logic                           i_CfgModEnable,
    input  logic                           i_CfgCarrier,
    input  logic                           i_NoteOn,
    input  logic [c_VW-1:0]                i_NoteOnVoice,
    output logic signed [SAMPLE_WIDTH-1:0] o_OpResult,
    output logic                           o_OpValid,
    output logic signed [SAMPLE_WIDTH-1:0] o_Sample,
    output logic                           o_SampleValid
);

    localparam int c_SLOTS = NUM_VOICES * NUM_OPERATORS;
    localparam int c_SW    = $clog2(c_SLOTS);
    localparam int c_ACC_W = SAMPLE_WIDTH + c_SW;
    localparam int c_PRD_W = SAMPLE_WIDTH + ENV_WIDTH + 1;
    localparam logic signed [c_ACC_W-1:0] c_SMAX =
        {{(c_SW + 1){1'b0}}, {(SAMPLE_WIDTH - 1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_SMIN =
        {{(c_SW + 1){1'b1}}, {(SAMPLE_WIDTH - 1){1'b0}}};

    // The modulation buffer is read one cycle after the next operator of a
    // voice issues; a frame row shorter than the pipeline would read stale data.
    generate
        if (NUM_VOICES < 8) begin : g_chk_voices
            $error("fm_voice_engine: NUM_VOICES must be >= 8");
        end
        if (NUM_OPERATORS < 1) begin : g_chk_ops
            $error("fm_voice_engine: NUM_OPERATORS must be >= 1");
        end
        if (PHASE_WIDTH < 13) begin : g_chk_phase
            $error("fm_voice_engine: PHASE_WIDTH must be >= 13");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Slot counter, kept as voice / operator pair (operator-major order)
    // ------------------------------------------------------------------
    logic [c_VW-1:0] r_voice;
    logic [c_OW-1:0] r_op;
    logic [c_SW-1:0] w_slot;
    logic            w_first;
    logic            w_last;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_voice <= '0;
            r_op    <= '0;
        end else if (r_voice == c_VW'(NUM_VOICES - 1)) begin
            r_voice <= '0;
            r_op    <= (r_op == c_OW'(NUM_OPERATORS - 1)) ? '0 : r_op + 1'b1;
        end else begin
            r_voice <= r_voice + 1'b1;
        end
    end

    assign w_slot        = c_SW'(int'(r_op) * NUM_VOICES + int'(r_voice));
    assign w_first       = (r_voice == '0) && (r_op == '0);
    assign w_last        = (r_voice == c_VW'(NUM_VOICES - 1)) &&
                           (r_op == c_OW'(NUM_OPERATORS - 1));
    assign o_CfgVoice    = r_voice;
    assign o_CfgOperator = r_op;

    // ------------------------------------------------------------------
    // Note-on: pending collects strobes; active is latched at frame start.
    // The frame-start cycle itself sees the freshly merged vector so a
    // note-on arriving exactly then already applies to slot 0.
    // ------------------------------------------------------------------
    logic [NUM_VOICES-1:0] r_pending;
    logic [NUM_VOICES-1:0] r_active;
    logic [NUM_VOICES-1:0] w_noteon_mask;
    logic [NUM_VOICES-1:0] w_active_now;

    always_comb begin
        w_noteon_mask = '0;
        if (i_NoteOn) begin
            w_noteon_mask[i_NoteOnVoice] = 1'b1;
        end
    end

    assign w_active_now = w_first ? (r_pending | w_noteon_mask) : r_active;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_pending <= '0;
            r_active  <= '0;
        end else if (w_first) begin
            r_active  <= r_pending | w_noteon_mask;
            r_pending <= '0;
        end else begin
            r_pending <= r_pending | w_noteon_mask;
        end
    end

    // ------------------------------------------------------------------
    // S0: phase accumulator per slot
    // ------------------------------------------------------------------
    logic [PHASE_WIDTH-1:0] r_acc [0:c_SLOTS-1];
    logic [PHASE_WIDTH-1:0] w_p;

    assign w_p = w_active_now[r_voice] ? '0 : r_acc[w_slot];

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            for (int i = 0; i < c_SLOTS; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            r_acc[w_slot] <= w_p + i_CfgPhaseStep;
        end
    end

    // ------------------------------------------------------------------
    // Sideband pipeline. Index k of each chain holds the slot issued k+1
    // cycles earlier.
    // ------------------------------------------------------------------
    logic [5:0]           r_vld;
    logic [6:0]           r_car_p;
    logic [6:0]           r_last_p;
    logic [c_VW-1:0]      r_voice_p [0:6];
    logic [ENV_WIDTH-1:0] r_env_p   [0:4];

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_vld     <= '0;
            o_OpValid <= 1'b0;
        end else begin
            r_vld     <= {r_vld[4:0], 1'b1};
            o_OpValid <= r_vld[5];
        end
    end

    always_ff @(posedge i_Clock) begin
        r_car_p      <= {r_car_p[5:0], i_CfgCarrier};
        r_last_p     <= {r_last_p[5:0], w_last};
        r_voice_p[0] <= r_voice;
        for (int k = 1; k < 7; k++) begin
            r_voice_p[k] <= r_voice_p[k-1];
        end
        r_env_p[0] <= i_CfgEnvelope;
        for (int k = 1; k < 5; k++) begin
            r_env_p[k] <= r_env_p[k-1];
        end
    end

    // ------------------------------------------------------------------
    // S1: add modulation term from previous operator of the same voice
    // ------------------------------------------------------------------
    logic [PHASE_WIDTH-1:0]         r_s1_p;
    logic                           r_s1_mod;
    logic signed [SAMPLE_WIDTH-1:0] r_modbuf [0:NUM_VOICES-1];
    logic signed [SAMPLE_WIDTH-1:0] w_mod_raw;
    logic [PHASE_WIDTH-1:0]         w_mod_term;
    logic [PHASE_WIDTH-1:0]         w_phase1;
    logic [12:0]                    r_phase13;

    assign w_mod_raw = r_modbuf[r_voice_p[0]];

    generate
        if (SAMPLE_WIDTH < PHASE_WIDTH) begin : g_mod_sext
            assign w_mod_term = {{(PHASE_WIDTH - SAMPLE_WIDTH){w_mod_raw[SAMPLE_WIDTH-1]}},
                                 w_mod_raw};
        end else begin : g_mod_top
            assign w_mod_term = PHASE_WIDTH'(w_mod_raw >>> (SAMPLE_WIDTH - PHASE_WIDTH));
        end
    endgenerate

    assign w_phase1 = r_s1_p + (r_s1_mod ? w_mod_term : '0);

    // ------------------------------------------------------------------
    // S2-S4: sine function on the top 13 phase bits. Each half-wave is the
    // parabola 4x(1-x) scaled to 32767, mirrored negative in the second half.
    // ------------------------------------------------------------------
    logic [11:0]        w_half;
    logic [12:0]        w_half_c;
    logic [22:0]        r_sa_prod;
    logic               r_sa_neg;
    logic [14:0]        r_sb_mag;
    logic               r_sb_neg;
    logic signed [15:0] r_sine16;

    assign w_half   = r_phase13[11:0];
    assign w_half_c = 13'd4096 - {1'b0, w_half};

    always_ff @(posedge i_Clock) begin
        r_s1_p    <= w_p;
        r_s1_mod  <= i_CfgModEnable && (r_op != '0);
        r_phase13 <= 13'(w_phase1 >> (PHASE_WIDTH - 13));
        r_sa_prod <= {11'd0, w_half} * {10'd0, w_half_c};
        r_sa_neg  <= r_phase13[12];
        r_sb_mag  <= 15'(({15'd0, r_sa_prod} * 38'd32767) >> 22);
        r_sb_neg  <= r_sa_neg;
        r_sine16  <= r_sb_neg ? -$signed({1'b0, r_sb_mag}) : $signed({1'b0, r_sb_mag});
    end

    logic signed [SAMPLE_WIDTH-1:0] w_sine;

    generate
        if (SAMPLE_WIDTH == 16) begin : g_sine_eq
            assign w_sine = r_sine16;
        end else if (SAMPLE_WIDTH > 16) begin : g_sine_up
            assign w_sine = {r_sine16, {(SAMPLE_WIDTH - 16){1'b0}}};
        end else begin : g_sine_dn
            assign w_sine = SAMPLE_WIDTH'(r_sine16 >>> (16 - SAMPLE_WIDTH));
        end
    endgenerate

    // ------------------------------------------------------------------
    // S5: envelope scaling (signed sine x zero-extended envelope)
    // S6: output register
    // ------------------------------------------------------------------
    logic signed [c_PRD_W-1:0]      w_sine_x;
    logic signed [c_PRD_W-1:0]      w_env_x;
    logic signed [c_PRD_W-1:0]      w_prod;
    logic signed [SAMPLE_WIDTH-1:0] r_res;

    assign w_sine_x = c_PRD_W'(w_sine);
    assign w_env_x  = {{(SAMPLE_WIDTH + 1){1'b0}}, r_env_p[4]};
    assign w_prod   = w_sine_x * w_env_x;

    always_ff @(posedge i_Clock) begin
        r_res <= SAMPLE_WIDTH'(w_prod >>> ENV_WIDTH);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_OpResult <= '0;
        end else begin
            o_OpResult <= r_res;
        end
    end

    // ------------------------------------------------------------------
    // Modulation buffer write-back and carrier mix
    // ------------------------------------------------------------------
    logic signed [c_ACC_W-1:0] r_mix;
    logic signed [c_ACC_W-1:0] w_addend;
    logic signed [c_ACC_W-1:0] w_sum;
    logic signed [c_ACC_W-1:0] w_clamped;

    always_comb begin
        w_addend  = r_car_p[6] ? c_ACC_W'(o_OpResult) : '0;
        w_sum     = r_mix + w_addend;
        w_clamped = w_sum;
        if (w_sum > c_SMAX) begin
            w_clamped = c_SMAX;
        end else if (w_sum < c_SMIN) begin
            w_clamped = c_SMIN;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_mix         <= '0;
            o_Sample      <= '0;
            o_SampleValid <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_modbuf[v] <= '0;
            end
        end else begin
            o_SampleValid <= 1'b0;
            if (o_OpValid) begin
                r_modbuf[r_voice_p[6]] <= o_OpResult;
                if (r_last_p[6]) begin
                    o_Sample      <= SAMPLE_WIDTH'(w_clamped);
                    o_SampleValid <= 1'b1;
                    r_mix         <= '0;
                end else begin
                    r_mix <= w_sum;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fm_voice_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_fm_voice_engine
// Description : Directed self-checking bench for fm_voice_engine
//               (16 voices x 6 operators, 16-bit widths).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_voice_engine;

    logic               clk = 1'b0;
    logic               i_Reset;
    logic [3:0]         o_CfgVoice;
    logic [2:0]         o_CfgOperator;
    logic [15:0]        i_CfgPhaseStep;
    logic [15:0]        i_CfgEnvelope;
    logic               i_CfgModEnable;
    logic               i_CfgCarrier;
    logic               i_NoteOn;
    logic [3:0]         i_NoteOnVoice;
    logic signed [15:0] o_OpResult;
    logic               o_OpValid;
    logic signed [15:0] o_Sample;
    logic               o_SampleValid;

    fm_voice_engine #(
        .NUM_VOICES   (16),
        .NUM_OPERATORS(6),
        .PHASE_WIDTH  (16),
        .ENV_WIDTH    (16),
        .SAMPLE_WIDTH (16)
    ) dut (
        .i_Clock       (clk),
        .i_Reset       (i_Reset),
        .o_CfgVoice    (o_CfgVoice),
        .o_CfgOperator (o_CfgOperator),
        .i_CfgPhaseStep(i_CfgPhaseStep),
        .i_CfgEnvelope (i_CfgEnvelope),
        .i_CfgModEnable(i_CfgModEnable),
        .i_CfgCarrier  (i_CfgCarrier),
        .i_NoteOn      (i_NoteOn),
        .i_NoteOnVoice (i_NoteOnVoice),
        .o_OpResult    (o_OpResult),
        .o_OpValid     (o_OpValid),
        .o_Sample      (o_Sample),
        .o_SampleValid (o_SampleValid)
    );

    always #5 clk = ~clk;

    // Per-slot configuration tables, served combinationally like a register file
    logic [15:0] tb_step [16][6];
    logic [15:0] tb_env  [16][6];
    logic        tb_mod  [16][6];
    logic        tb_car  [16][6];

    always_comb begin
        i_CfgPhaseStep = tb_step[o_CfgVoice][o_CfgOperator];
        i_CfgEnvelope  = tb_env[o_CfgVoice][o_CfgOperator];
        i_CfgModEnable = tb_mod[o_CfgVoice][o_CfgOperator];
        i_CfgCarrier   = tb_car[o_CfgVoice][o_CfgOperator];
    end

    // Cycle index since reset release (0 = first issue cycle)
    int cyc;
    always @(posedge clk) begin
        if (i_Reset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        for (int i = 0; i < 20000 && cyc < c; i++) @(negedge clk);
        if (cyc != c) begin
            checks++;
            errors++;
            $error("FAIL wait_cyc: observed cycle %0d expected %0d", cyc, c);
        end
    endtask

    task automatic clear_tables();
        for (int v = 0; v < 16; v++) begin
            for (int o = 0; o < 6; o++) begin
                tb_step[v][o] = 16'h0000;
                tb_env[v][o]  = 16'h0000;
                tb_mod[v][o]  = 1'b0;
                tb_car[v][o]  = 1'b0;
            end
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        i_Reset = 1'b1;
        @(negedge clk);
        i_Reset = 1'b0;
    endtask

    // Reference half-wave parabola sine on the top 13 phase bits
    function automatic logic signed [15:0] sine_m(input logic [15:0] ph);
        longint h, mag;
        h   = longint'(ph[14:3]);
        mag = (h * (4096 - h) * 32767) / 4194304;
        return ph[15] ? 16'(-mag) : 16'(mag);
    endfunction

    function automatic logic [15:0] op_m(input logic [15:0] ph, input logic [15:0] env);
        longint p;
        p = longint'(sine_m(ph)) * longint'(env);
        return 16'(p >>> 16);
    endfunction

    initial begin
        int seen;
        i_Reset       = 1'b1;
        i_NoteOn      = 1'b0;
        i_NoteOnVoice = 4'd0;
        clear_tables();
        repeat (3) @(negedge clk);

        // ---------------- reset state ----------------
        check("rst_opvalid", o_OpValid, 16'd0);
        check("rst_opresult", o_OpResult, 16'd0);
        check("rst_sample", o_Sample, 16'd0);
        check("rst_samplevalid", o_SampleValid, 16'd0);
        check("rst_cfgvoice", o_CfgVoice, 16'd0);
        check("rst_cfgop", o_CfgOperator, 16'd0);

        // ---------------- latency with all envelopes zero ----------------
        i_Reset = 1'b0;
        wait_cyc(6);
        check("lat_opvalid_c6", o_OpValid, 16'd0);
        wait_cyc(7);
        check("lat_opvalid_c7", o_OpValid, 16'd1);
        check("lat_opresult_c7", o_OpResult, 16'd0);
        wait_cyc(102);
        check("lat_sv_c102", o_SampleValid, 16'd0);
        wait_cyc(103);
        check("lat_sv_c103", o_SampleValid, 16'd1);
        check("lat_sample_c103", o_Sample, 16'd0);
        wait_cyc(104);
        check("lat_sv_c104", o_SampleValid, 16'd0);
        wait_cyc(199);
        check("lat_sv_c199", o_SampleValid, 16'd1);

        // ---------------- single carrier sweep, period 64 frames ----------------
        clear_tables();
        tb_step[0][0] = 16'h0400;
        tb_env[0][0]  = 16'hFFFF;
        tb_car[0][0]  = 1'b1;
        reset_dut();
        for (int k = 0; k < 66; k++) begin
            wait_cyc(96 * k + 103);
            check($sformatf("sweep_sv_f%0d", k), o_SampleValid, 16'd1);
            check($sformatf("sweep_sample_f%0d", k), o_Sample,
                  op_m(16'(k * 16'h0400), 16'hFFFF));
        end

        // ---------------- operator 0 modulating operator 1 ----------------
        clear_tables();
        tb_step[0][0] = 16'h4000;
        tb_env[0][0]  = 16'hFFFF;
        tb_env[0][1]  = 16'hFFFF;
        tb_mod[0][1]  = 1'b1;
        tb_car[0][1]  = 1'b1;
        reset_dut();
        wait_cyc(103);
        check("mod_sample_f0", o_Sample, 16'd0);
        check("mod_op0_valid_f1", o_OpValid, 16'd1);
        check("mod_op0_f1", o_OpResult, 16'h7FFE);
        wait_cyc(119);
        check("mod_op1_f1", o_OpResult, 16'h001E);
        check("mod_op1_f1_model", o_OpResult, op_m(16'h7FFE, 16'hFFFF));
        wait_cyc(199);
        check("mod_sample_f1", o_Sample, 16'h001E);
        tb_mod[0][1] = 1'b0;
        wait_cyc(487);
        check("nomod_op0_f5", o_OpResult, 16'h7FFE);
        wait_cyc(503);
        check("nomod_op1_f5", o_OpResult, 16'd0);
        wait_cyc(583);
        check("nomod_sample_f5", o_Sample, 16'd0);

        // ---------------- saturation ----------------
        for (int v = 0; v < 16; v++) begin
            for (int o = 0; o < 6; o++) begin
                tb_step[v][o] = 16'h4000;
                tb_env[v][o]  = 16'hFFFF;
                tb_mod[v][o]  = 1'b0;
                tb_car[v][o]  = 1'b1;
            end
        end
        reset_dut();
        wait_cyc(103);
        check("sat_sample_f0", o_Sample, 16'd0);
        wait_cyc(199);
        check("sat_sample_pos", o_Sample, 16'h7FFF);
        wait_cyc(295);
        check("sat_sample_f2", o_Sample, 16'd0);
        wait_cyc(391);
        check("sat_sample_neg", o_Sample, 16'h8000);

        // ---------------- note-on phase reset, voice 3 ----------------
        clear_tables();
        for (int o = 0; o < 6; o++) begin
            tb_step[3][o] = 16'h1000;
            tb_env[3][o]  = 16'hFFFF;
        end
        tb_car[3][0] = 1'b1;
        reset_dut();
        wait_cyc(202);
        check("non_f2_slot3", o_OpResult, op_m(16'h2000, 16'hFFFF));
        wait_cyc(232);
        i_NoteOn      = 1'b1;
        i_NoteOnVoice = 4'd3;
        @(negedge clk);
        i_NoteOn = 1'b0;
        wait_cyc(250);
        check("non_f2_slot51", o_OpResult, op_m(16'h2000, 16'hFFFF));
        wait_cyc(298);
        check("non_f3_slot3", o_OpResult, 16'd0);
        wait_cyc(346);
        check("non_f3_slot51", o_OpResult, 16'd0);
        wait_cyc(384);
        i_NoteOn      = 1'b1;
        i_NoteOnVoice = 4'd3;
        @(negedge clk);
        i_NoteOn = 1'b0;
        wait_cyc(394);
        check("non_s0_f4_slot3", o_OpResult, 16'd0);
        wait_cyc(442);
        check("non_s0_f4_slot51", o_OpResult, 16'd0);
        wait_cyc(490);
        check("non_f5_slot3", o_OpResult, op_m(16'h1000, 16'hFFFF));
        wait_cyc(538);
        check("non_f5_slot51", o_OpResult, op_m(16'h1000, 16'hFFFF));
        wait_cyc(583);
        check("non_f5_sample", o_Sample, op_m(16'h1000, 16'hFFFF));

        // ---------------- reset mid-frame at slot 50 ----------------
        wait_cyc(626);
        i_Reset = 1'b1;
        @(negedge clk);
        check("mrst_opvalid", o_OpValid, 16'd0);
        check("mrst_opresult", o_OpResult, 16'd0);
        check("mrst_sample", o_Sample, 16'd0);
        check("mrst_samplevalid", o_SampleValid, 16'd0);
        check("mrst_cfgvoice", o_CfgVoice, 16'd0);
        check("mrst_cfgop", o_CfgOperator, 16'd0);
        i_Reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && cyc < 103; i++) begin
            if (o_SampleValid) seen++;
            @(negedge clk);
        end
        check("mrst_no_sv_early", 16'(seen), 16'd0);
        wait_cyc(103);
        check("mrst_sv_c103", o_SampleValid, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
